gate_drive_supervisor: RTL

//  Sits between Current_Loop PWM outputs and the three half-bridge drivers (oSD_u_n/v/w_n, oPWM_u/v/w).

---
 rtl/gate_drive_if.sv | 35 +++
 rtl/gate_drive_supervisor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gate_drive_if.sv
// Signal bundle between the current loop and the gate-drive supervisor.
// The master drives the inputs and the slave (supervisor) drives the pins.
interface gate_drive_if;
  logic       iPll_locked;
  logic       iPwm_u;
  logic       iPwm_v;
  logic       iPwm_w;
  logic       iModulate_done;
  logic       iEnc_warning;
  logic       iOc_n;
  logic       iClear_fault;
  logic       oPWM_u;
  logic       oPWM_v;
  logic       oPWM_w;
  logic       oSD_u_n;
  logic       oSD_v_n;
  logic       oSD_w_n;
  logic       oRun;
  logic       oFault;
  logic [1:0] oFault_code;

  modport master (
    output iPll_locked, iPwm_u, iPwm_v, iPwm_w, iModulate_done,
           iEnc_warning, iOc_n, iClear_fault,
    input  oPWM_u, oPWM_v, oPWM_w, oSD_u_n, oSD_v_n, oSD_w_n,
           oRun, oFault, oFault_code
  );

  modport slave (
    input  iPll_locked, iPwm_u, iPwm_v, iPwm_w, iModulate_done,
           iEnc_warning, iOc_n, iClear_fault,
    output oPWM_u, oPWM_v, oPWM_w, oSD_u_n, oSD_v_n, oSD_w_n,
           oRun, oFault, oFault_code
  );
endinterface

// File: rtl/gate_drive_supervisor.sv
// Half-bridge driver sequencing (lock, bootstrap precharge, run) with PWM gating
// and latched overcurrent / encoder / heartbeat faults.
module gate_drive_supervisor #(
  parameter int PRECHARGE_CYC = 100000,
  parameter int WDT_CYC       = 25000,
  parameter int OC_FILT       = 8,
  parameter int ENC_FILT      = 4,
  parameter int HOLDOFF_CYC   = 1000000
) (
  input  logic        nclk_100m,
  input  logic        iRst_n,
  gate_drive_if.slave bus
);

  localparam int TMR_MAX = (PRECHARGE_CYC > HOLDOFF_CYC) ? PRECHARGE_CYC : HOLDOFF_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WDT_W   = $clog2(WDT_CYC + 1);
  localparam int OC_W    = $clog2(OC_FILT + 1);
  localparam int ENC_W   = $clog2(ENC_FILT + 1);

  // IDLE: wait lock | PRECHARGE: low side on | RUN: PWM passed | FAULT: latched, clear + holdoff
  typedef enum logic [1:0] {ST_IDLE, ST_PRECHARGE, ST_RUN, ST_FAULT} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               holdoff_q, holdoff_d;
  logic               oc_s1_q, oc_s1_d, oc_s2_q, oc_s2_d;
  logic [OC_W-1:0]    oc_cnt_q, oc_cnt_d;
  logic [ENC_W-1:0]   enc_cnt_q, enc_cnt_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic [1:0]         code_q, code_d;
  logic               pwm_u_q, pwm_u_d, pwm_v_q, pwm_v_d, pwm_w_q, pwm_w_d;
  logic               sd_n_q, sd_n_d, run_q, run_d, fault_q, fault_d;
  logic               oc_trip, enc_trip, wdt_trip, detect;
  logic [1:0]         cause;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    holdoff_d = holdoff_q;
    code_d    = code_q;
    oc_s1_d   = bus.iOc_n;
    oc_s2_d   = oc_s1_q;
    oc_cnt_d  = oc_cnt_q;
    enc_cnt_d = enc_cnt_q;
    wdt_cnt_d = wdt_cnt_q;

    detect   = (state_q != ST_IDLE);
    oc_trip  = detect && (oc_cnt_q == OC_W'(OC_FILT));
    enc_trip = detect && (enc_cnt_q == ENC_W'(ENC_FILT));
    // Trips on the edge where the count would reach WDT_CYC.
    wdt_trip = (state_q == ST_RUN) && !bus.iModulate_done &&
               (wdt_cnt_q >= WDT_W'(WDT_CYC - 1));
    cause    = oc_trip ? 2'd1 : (enc_trip ? 2'd2 : 2'd3);

    if (!detect || oc_s2_q)  oc_cnt_d = '0;
    else if (!oc_trip)       oc_cnt_d = oc_cnt_q + 1'b1;

    if (!detect)
      enc_cnt_d = '0;
    else if (bus.iModulate_done) begin
      if (!bus.iEnc_warning) enc_cnt_d = '0;
      else if (!enc_trip)    enc_cnt_d = enc_cnt_q + 1'b1;
    end

    if (state_q != ST_RUN || bus.iModulate_done) wdt_cnt_d = '0;
    else if (wdt_cnt_q != WDT_W'(WDT_CYC))        wdt_cnt_d = wdt_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tmr_d     = '0;
        holdoff_d = 1'b0;
        if (bus.iPll_locked) state_d = ST_PRECHARGE;
      end
      ST_PRECHARGE: begin
        if (oc_trip || enc_trip) begin
          state_d = ST_FAULT;
          code_d  = cause;
          tmr_d   = '0;
        end else if (!bus.iPll_locked) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(PRECHARGE_CYC - 1)) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (oc_trip || enc_trip || wdt_trip || !bus.iPll_locked) begin
          state_d = ST_FAULT;
          code_d  = cause;
          tmr_d   = '0;
        end
      end
      default: begin
        if (!holdoff_q) begin
          if (bus.iClear_fault && oc_s2_q && !bus.iEnc_warning) begin
            holdoff_d = 1'b1;
            tmr_d     = '0;
            enc_cnt_d = '0;
          end
        end else if (oc_trip || enc_trip) begin
          // A fresh fault during holdoff re-arms the clear; first cause stays latched.
          holdoff_d = 1'b0;
          tmr_d     = '0;
        end else if (tmr_q == TMR_W'(HOLDOFF_CYC - 1)) begin
          state_d   = ST_IDLE;
          holdoff_d = 1'b0;
          tmr_d     = '0;
          code_d    = 2'd0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    endcase

    sd_n_d  = (state_d == ST_PRECHARGE) || (state_d == ST_RUN);
    run_d   = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
    pwm_u_d = run_d && bus.iPwm_u;
    pwm_v_d = run_d && bus.iPwm_v;
    pwm_w_d = run_d && bus.iPwm_w;
  end

  always_ff @(posedge nclk_100m or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      holdoff_q <= 1'b0;
      oc_s1_q   <= 1'b1;
      oc_s2_q   <= 1'b1;
      oc_cnt_q  <= '0;
      enc_cnt_q <= '0;
      wdt_cnt_q <= '0;
      code_q    <= 2'd0;
      pwm_u_q   <= 1'b0;
      pwm_v_q   <= 1'b0;
      pwm_w_q   <= 1'b0;
      sd_n_q    <= 1'b0;
      run_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      holdoff_q <= holdoff_d;
      oc_s1_q   <= oc_s1_d;
      oc_s2_q   <= oc_s2_d;
      oc_cnt_q  <= oc_cnt_d;
      enc_cnt_q <= enc_cnt_d;
      wdt_cnt_q <= wdt_cnt_d;
      code_q    <= code_d;
      pwm_u_q   <= pwm_u_d;
      pwm_v_q   <= pwm_v_d;
      pwm_w_q   <= pwm_w_d;
      sd_n_q    <= sd_n_d;
      run_q     <= run_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.oPWM_u      = pwm_u_q;
  assign bus.oPWM_v      = pwm_v_q;
  assign bus.oPWM_w      = pwm_w_q;
  assign bus.oSD_u_n     = sd_n_q;
  assign bus.oSD_v_n     = sd_n_q;
  assign bus.oSD_w_n     = sd_n_q;
  assign bus.oRun        = run_q;
  assign bus.oFault      = fault_q;
  assign bus.oFault_code = code_q;

endmodule
